// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-read-port register file.
// Defaults for the size parameters and the index of the hardwired zero register.
package reg_file_pkg;

  localparam int DATA_W_D   = 32;
  localparam int ADDR_W_D   = 5;
  localparam int DEPTH_D    = 32;
  localparam int NUM_RD_D   = 2;
  localparam int ZERO_REG_D = 1;

  // Index of the hardwired zero register (active when ZERO_REG = 1)
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of reg_file_mp.
// Applies the range/zero-register mask and the optional write-through bypass.
// It then registers rd_data/rd_busy with 1-cycle latency.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (same-cycle write forwarding).
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int ZERO_REG = ZERO_REG_D
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] ent_data_i,
  input  logic              ent_pend_i,
  input  logic              wr_ok_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              iss_ok_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);

  logic              addr_ok;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_busy_d, rd_busy_q;

  // Unimplemented addresses and the zero register always read as idle zero
  assign addr_ok = (32'(rd_addr_i) < DEPTH) &&
                   !((ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO)));

`ifndef REG_FILE_MP_BYPASS_EN
  // Write-port inputs only matter when forwarding is compiled in
  logic bypass_unused;
  assign bypass_unused = ^{wr_ok_i, wr_addr_i, wr_data_i, iss_ok_i, iss_addr_i};
`endif

  // Select the value to capture: stored entry, optionally forwarded write data, then mask
  always_comb begin
    rd_data_d = ent_data_i;
    rd_busy_d = ent_pend_i;
`ifdef REG_FILE_MP_BYPASS_EN
    if (wr_ok_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
      // The write clears pending; only a same-cycle issue re-sets it
      rd_busy_d = iss_ok_i && (iss_addr_i == rd_addr_i);
    end
`endif
    if (!addr_ok) begin
      rd_data_d = '0;
      rd_busy_d = 1'b0;
    end
  end

  // Output registers give the 1-cycle read latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a per-entry pending scoreboard.
// Decode reads and issues destinations; writeback writes entries and clears pending.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (same-cycle write forwarding on reads).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int NUM_RD   = NUM_RD_D,
  parameter int ZERO_REG = ZERO_REG_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  // Full address space; entries at or above DEPTH read as constant zero
  localparam int NUM_ENT = 1 << ADDR_W;

  logic                wr_ok;
  logic                iss_ok;
  logic [DATA_W-1:0]   ent_ext [NUM_ENT];
  logic [NUM_ENT-1:0]  pend_ext;
  logic [DEPTH-1:0]    pend_d, pend_q;
  logic                cnt_inc, cnt_dec;
  logic [ADDR_W:0]     pend_cnt_d, pend_cnt_q;

  // Writes and issues only take effect on implemented, non-zero-register entries
  assign wr_ok  = wr_en && (32'(wr_addr) < DEPTH) &&
                  !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
  assign iss_ok = iss_en && (32'(iss_addr) < DEPTH) &&
                  !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENT; gi++) begin : g_ent
      if (gi < DEPTH) begin : g_impl
        logic [DATA_W-1:0] ent_q;

        // Entry storage, written by a qualifying writeback
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ent_q <= '0;
          end else if (wr_ok && (wr_addr == ADDR_W'(gi))) begin
            ent_q <= wr_data;
          end
        end

        assign ent_ext[gi]  = ent_q;
        assign pend_ext[gi] = pend_q[gi];
        // Clear on writeback, then set on issue so a same-cycle issue wins
        assign pend_d[gi]   = (pend_q[gi] && !(wr_ok && (wr_addr == ADDR_W'(gi)))) ||
                              (iss_ok && (iss_addr == ADDR_W'(gi)));
      end else begin : g_none
        assign ent_ext[gi]  = '0;
        assign pend_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Pending scoreboard bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A set counts only on a clear entry; a clear counts only if no same-address issue re-sets it
  assign cnt_inc = iss_ok && !pend_ext[iss_addr];
  assign cnt_dec = wr_ok && pend_ext[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

  // Incremental population count of the pending bits
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      pend_cnt_d = pend_cnt_q + (ADDR_W + 1)'(1);
    end else if (cnt_dec && !cnt_inc) begin
      pend_cnt_d = pend_cnt_q - (ADDR_W + 1)'(1);
    end
  end

  // Pending count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt_q <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      assign port_addr = rd_addr[gi*ADDR_W +: ADDR_W];

      reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
      ) u_rd_port (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_addr_i  (port_addr),
        .ent_data_i (ent_ext[port_addr]),
        .ent_pend_i (pend_ext[port_addr]),
        .wr_ok_i    (wr_ok),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .iss_ok_i   (iss_ok),
        .iss_addr_i (iss_addr),
        .rd_data_o  (rd_data[gi*DATA_W +: DATA_W]),
        .rd_busy_o  (rd_busy[gi])
      );
    end
  endgenerate

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file with a per-entry pending scoreboard. It succeeds the single-clock 2R/1W 32x32 datapath register file.
- Adds the following over its predecessor:
  - registered reads with 1-cycle latency
  - posedge-only writes
  - hardwired zero register
  - out-of-range address protection
  - a pending/busy scoreboard that lets the decode stage detect RAW hazards against in-flight writebacks
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, address width
- DEPTH, 32, number of implemented registers (must satisfy 2 <= DEPTH <= 2**ADDR_W)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes and issues

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  registered pending flag for each read port's address
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination being issued
- pend_cnt  out  ADDR_W+1  number of entries currently pending

Behaviour:
- Reset (rst_n low, async, independent of clk):
  - all entries = 0
  - pending[] = 0
  - rd_data = 0, rd_busy = 0, pend_cnt = 0
  - Reset asserted mid-operation discards any same-cycle write/issue. First update occurs at the first posedge after rst_n rises.
- Write: at posedge, entry[wr_addr] <= wr_data when all of the following hold:
  - wr_en = 1
  - wr_addr < DEPTH
  - not (ZERO_REG and wr_addr == 0)
  - Otherwise the write is silently dropped.
- Read: at posedge, for each p, rd_data[p] <= entry[rd_addr[p]]. Latency is 1 cycle.
  - Returns 0 if rd_addr[p] >= DEPTH, or if ZERO_REG and rd_addr[p] == 0.
- Read/write collision (same posedge, same address): governed by the optional feature below.
- Scoreboard:
  - iss_en sets pending[iss_addr].
  - A qualifying write clears pending[wr_addr].
  - Same cycle, same address for issue and write: pending ends set (the new issue wins).
  - Issues to address 0 (when ZERO_REG) or to out-of-range addresses are ignored.
  - Issue to an already-pending entry: it stays set and pend_cnt is unchanged.
- rd_busy[p]: registered with rd_data. It equals pending[rd_addr[p]] before the edge, adjusted per the collision rule. It is always 0 for address 0 (when ZERO_REG) and for out-of-range addresses.
- pend_cnt: registered population count of pending[] after the edge update.
  - Incremental update: +1 for a set on a clear entry, -1 for a clear on a set entry, net 0 for a simultaneous set and clear on the same address.
  - Never wraps: maximum value is DEPTH.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a same-cycle qualifying write to rd_addr[p] forwards wr_data to rd_data[p]. rd_busy[p] then reflects pending after the clear (0, unless the same-cycle issue re-sets it).
- Undefined: rd_data[p] returns the pre-write value and rd_busy[p] returns the pre-edge pending bit. The new value is visible on the next read.

Decomposition:
- Package reg_file_pkg holds:
  - default constants DATA_W_D = 32, ADDR_W_D = 5, DEPTH_D = 32, NUM_RD_D = 2
  - zero-register index constant REG_ZERO = 0
- One natural sub-module: reg_file_rd_port, one per read port via generate. It contains the address-range/zero check, the bypass mux and the rd_data/rd_busy output registers.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle with entries written -> rd_data = 0, rd_busy = 0 and pend_cnt = 0 immediately, without waiting for clk. Read addr 7 after release -> 0.
- Write/read: write 0xDEADBEEF to addr 5, then read port 0 = 5 and port 1 = 5 on the next edge -> both rd_data = 0xDEADBEEF one cycle later.
- Zero register: write 0x1234 to addr 0 and issue addr 0 -> read addr 0 gives 0, rd_busy = 0, pend_cnt = 0.
- Collision on addr 9 (old 0x11, wr_data 0x22, read same edge):
  - with REG_FILE_MP_BYPASS_EN defined -> rd_data = 0x22
  - without it -> rd_data = 0x11, then 0x22 on the next read
- Scoreboard:
  - issue 3, 4, 3 -> pend_cnt = 2
  - read 3 -> rd_busy = 1
  - write 3 -> pend_cnt = 1
  - simultaneous issue 4 and write 4 -> pend_cnt stays 1 and rd_busy(4) = 1
- Out-of-range (DEPTH = 24): write and issue addr 30 -> dropped; read addr 30 -> 0, busy 0, pend_cnt unchanged.
